// File: rtl/keys_debounce_module.sv
// Four-key debouncer: two-flop synchroniser plus an independent debounce FSM per key,
// producing a one-cycle press pulse and a debounced held level for each key.
module keys_debounce_module #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] keys_n,
    output logic [3:0] key_pulse,
    output logic [3:0] key_level
);

    localparam int unsigned NUM_KEYS = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [NUM_KEYS-1:0] sync_q1;
    logic [NUM_KEYS-1:0] sync_q2;

    // Synchronisers reset to the released level so reset never looks like a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= keys_n;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             pulse;
        logic             level;

        // Any departure from the stable run restarts the debounce from the opposite state.
        always_ff @(posedge CLK) begin
            if (RST) begin
                state <= IDLE;
                cnt   <= '0;
                pulse <= 1'b0;
                level <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (state)
                    IDLE: begin
                        if (!sync_q2[k]) begin
                            state <= PRESS_WAIT;
                            cnt   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (sync_q2[k]) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= PRESSED;
                            cnt   <= '0;
                            pulse <= 1'b1;
                            level <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (sync_q2[k]) begin
                            state <= RELEASE_WAIT;
                            cnt   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!sync_q2[k]) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            level <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end

        assign key_pulse[k] = pulse;
        assign key_level[k] = level;
    end

endmodule

// File: tb/tb_keys_debounce_module.sv
// Bench for keys_debounce_module: directed press/bounce/reset scenarios followed by random
// bouncing, all checked against a run-length reference model of the debouncer.
module tb_keys_debounce_module;

    localparam int unsigned D = 4;

    logic       CLK;
    logic       RST;
    logic [3:0] keys_n;
    logic [3:0] key_pulse;
    logic [3:0] key_level;

    keys_debounce_module #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .keys_n    (keys_n),
        .key_pulse (key_pulse),
        .key_level (key_level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: raw samples delayed two edges, then per key an accepted level and the
    // length of the current run of samples that disagree with it.
    logic [3:0] raw_q[$];
    logic [3:0] m_level;
    logic [3:0] m_pulse;
    int         run_len[4];

    int         ecnt = 0;
    int         last_pulse_edge = -1;
    logic [3:0] last_pulse = '0;
    int         pcnt[4];
    int         fall_edge2 = -1;
    logic       prev_lvl2 = 1'b0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, ecnt);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [3:0] kn, input logic rst);
        logic [3:0] s;
        m_pulse = '0;
        if (rst) begin
            raw_q.delete();
            raw_q.push_back(4'hF);
            raw_q.push_back(4'hF);
            m_level = '0;
            for (int i = 0; i < 4; i++) run_len[i] = 0;
        end else begin
            s = raw_q.pop_front();
            raw_q.push_back(kn);
            for (int i = 0; i < 4; i++) begin
                // pressed level disagrees with a released sample and vice versa
                if (s[i] == m_level[i]) begin
                    run_len[i]++;
                    if (run_len[i] == int'(D) + 1) begin
                        m_level[i] = ~m_level[i];
                        run_len[i] = 0;
                        if (m_level[i]) m_pulse[i] = 1'b1;
                    end
                end else begin
                    run_len[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] kn, input logic rst);
        keys_n = kn;
        RST    = rst;
        @(posedge CLK);
        ecnt++;
        model_edge(kn, rst);
        #1;
        chk("key_pulse", key_pulse, m_pulse);
        chk("key_level", key_level, m_level);
        if (key_pulse != 4'b0000) begin
            last_pulse_edge = ecnt;
            last_pulse      = key_pulse;
            for (int i = 0; i < 4; i++) if (key_pulse[i]) pcnt[i]++;
        end
        if (prev_lvl2 && !key_level[2]) fall_edge2 = ecnt;
        prev_lvl2 = key_level[2];
    endtask

    task automatic steps(input logic [3:0] kn, input int n);
        for (int j = 0; j < n; j++) step(kn, 1'b0);
    endtask

    initial begin
        int e0;
        int base;
        logic [3:0] kn;

        for (int i = 0; i < 4; i++) begin
            pcnt[i]    = 0;
            run_len[i] = 0;
        end
        m_level = '0;
        m_pulse = '0;
        keys_n  = 4'hF;
        RST     = 1'b1;

        // 1: reset held with all keys pressed, then the normal press sequence
        for (int j = 0; j < 3; j++) begin
            step(4'b0000, 1'b1);
            chk("rst_pulse", key_pulse, 4'b0000);
            chk("rst_level", key_level, 4'b0000);
        end
        e0 = ecnt + 1;
        steps(4'b0000, 10);
        chk_int("t1_pulse_edge", last_pulse_edge, e0 + 6);
        chk("t1_pulse_val", last_pulse, 4'b1111);
        steps(4'b1111, 12);
        chk("t1_released", key_level, 4'b0000);

        // 2: clean press of key 0 held for a long time
        base = pcnt[0];
        e0 = ecnt + 1;
        steps(4'b1110, 106);
        chk_int("t2_pulse_edge", last_pulse_edge, e0 + 6);
        chk_int("t2_pulse_count", pcnt[0], base + 1);
        chk("t2_level", key_level, 4'b0001);
        steps(4'b1111, 12);

        // 3: press bounce on key 1
        base = pcnt[1];
        steps(4'b1101, 3);
        steps(4'b1111, 1);
        steps(4'b1101, 2);
        steps(4'b1111, 1);
        chk_int("t3_no_bounce_pulse", pcnt[1], base);
        e0 = ecnt + 1;
        steps(4'b1101, 12);
        chk_int("t3_pulse_edge", last_pulse_edge, e0 + 6);
        chk_int("t3_pulse_count", pcnt[1], base + 1);
        steps(4'b1111, 12);

        // 4: release bounce on key 2 after an accepted press
        base = pcnt[2];
        steps(4'b1011, 10);
        steps(4'b1111, 2);
        steps(4'b1011, 1);
        chk("t4_level_held", key_level, 4'b0100);
        e0 = ecnt + 1;
        steps(4'b1111, 10);
        chk_int("t4_fall_edge", fall_edge2, e0 + 6);
        chk_int("t4_pulse_count", pcnt[2], base + 1);

        // 5: simultaneous press of keys 0 and 3
        steps(4'b0110, 10);
        chk("t5_pulse_val", last_pulse, 4'b1001);
        chk("t5_level", key_level, 4'b1001);
        steps(4'b1111, 12);

        // 6: reset during key 3 debounce, key kept held
        base = pcnt[3];
        steps(4'b0111, 5);
        step(4'b0111, 1'b1);
        chk_int("t6_aborted", pcnt[3], base);
        e0 = ecnt + 1;
        steps(4'b0111, 10);
        chk_int("t6_pulse_edge", last_pulse_edge, e0 + 6);
        chk_int("t6_pulse_count", pcnt[3], base + 1);
        steps(4'b1111, 12);

        // random bouncing with occasional resets
        kn = 4'hF;
        for (int j = 0; j < 800; j++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) kn[i] = ~kn[i];
            step(kn, ($urandom_range(0, 149) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
